// File: rtl/tile_pkg.sv
// tile_pkg: shared tile encodings, default colours and tile code-to-value mapping
package tile_pkg;
  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_DIM    = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_INVERT = 2'b11
  } mode_e;
  localparam logic [3:0]  CODE_EMPTY    = 4'd0;
  localparam logic [23:0] DEF_BG_COLOR  = 24'hCDC1B4;
  localparam logic [23:0] DEF_ERR_COLOR = 24'hFF00FF;
  // code k shows 2^(k-1); code 1 is the index tile with value 1
  function automatic logic [15:0] tile_value(input logic [3:0] code);
    return code == CODE_EMPTY ? 16'd0 : 16'd1 << (code - 4'd1);
  endfunction
endpackage

// File: rtl/px_sideband_pipe.sv
// px_sideband_pipe: DEPTH-stage shift register carrying {valid, code, mode, phase}
//   clk, rst   : clock, synchronous clear of every stage
//   in_*       : request sideband entering stage 0
//   out_*      : sideband leaving the last stage
module px_sideband_pipe #(
  parameter int DEPTH  = 2,
  parameter int CODE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  input  logic [1:0]        in_mode,
  input  logic              in_phase,
  output logic              out_valid,
  output logic [CODE_W-1:0] out_code,
  output logic [1:0]        out_mode,
  output logic              out_phase
);
  localparam int W = CODE_W + 4;
  logic [W-1:0] sr_d [DEPTH];
  logic [W-1:0] sr_q [DEPTH];
  always_comb begin
    sr_d[0] = {in_valid, in_code, in_mode, in_phase};
    for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) sr_q[i] <= rst ? '0 : sr_d[i];
  end
  assign {out_valid, out_code, out_mode, out_phase} = sr_q[DEPTH-1];
endmodule

// File: rtl/tile_px_fetch.sv
// tile_px_fetch: pipelined tile ROM pixel fetch with blank/error/dim/blink/invert processing
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/code/x/y/mode   : pixel request, one per cycle max
//   frame_tick, err_clr      : frame counter advance, sticky error clear
//   rom_addr, rom_data       : shared ROM address, flattened ROM outputs (slice k = ROM k)
//   out_valid, out_px        : processed pixel, ROM_LAT+2 cycles after the request
//   err_sticky               : set when an out-of-range code matures
module tile_px_fetch
  import tile_pkg::*;
#(
  parameter int              NUM_TILES = 12,
  parameter int              CODE_W    = 4,
  parameter int              COORD_W   = 6,
  parameter int              ADDR_W    = 12,
  parameter int              PX_W      = 24,
  parameter int              ROM_LAT   = 1,
  parameter logic [PX_W-1:0] BG_COLOR  = DEF_BG_COLOR,
  parameter logic [PX_W-1:0] ERR_COLOR = DEF_ERR_COLOR,
  parameter int              BLINK_W   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [CODE_W-1:0]         in_code,
  input  logic [COORD_W-1:0]        in_x,
  input  logic [COORD_W-1:0]        in_y,
  input  logic [1:0]                in_mode,
  input  logic                      frame_tick,
  input  logic                      err_clr,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [NUM_TILES*PX_W-1:0] rom_data,
  output logic                      out_valid,
  output logic [PX_W-1:0]           out_px,
  output logic                      err_sticky
);
  localparam int CH_W = PX_W / 3;
  localparam logic [CODE_W-1:0] MAX_CODE = CODE_W'(NUM_TILES);
  logic [ADDR_W-1:0]  rom_addr_d, rom_addr_q;
  logic [BLINK_W-1:0] frame_d, frame_q;
  logic               out_valid_d, out_valid_q;
  logic [PX_W-1:0]    out_px_d, out_px_q;
  logic               err_d, err_q;
  logic               sb_valid, sb_phase, is_err;
  logic [CODE_W-1:0]  sb_code;
  logic [1:0]         sb_mode;
  logic [PX_W-1:0]    rom_word, base_px, dim_px, mode_px;
  // sideband is one stage longer than the ROM so the select lines up with the returning word
  px_sideband_pipe #(.DEPTH(ROM_LAT + 1), .CODE_W(CODE_W)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .in_mode   (in_mode),
    .in_phase  (frame_q[BLINK_W-1]),
    .out_valid (sb_valid),
    .out_code  (sb_code),
    .out_mode  (sb_mode),
    .out_phase (sb_phase)
  );
  always_comb begin
    rom_word = '0;
    for (int k = 0; k < NUM_TILES; k++) if (sb_code == CODE_W'(k + 1)) rom_word = rom_data[k*PX_W +: PX_W];
    is_err = sb_code > MAX_CODE;
    base_px = sb_code == CODE_W'(CODE_EMPTY) ? BG_COLOR : rom_word;
    dim_px = '0;
    for (int c = 0; c < 3; c++) dim_px[c*CH_W +: CH_W] = base_px[c*CH_W +: CH_W] >> 1;
    mode_px = is_err                   ? ERR_COLOR :
              sb_mode == MODE_DIM      ? dim_px :
              sb_mode == MODE_BLINK    ? (sb_phase ? BG_COLOR : base_px) :
              sb_mode == MODE_INVERT   ? ~base_px : base_px;
    rom_addr_d = in_valid ? {in_y, in_x} : rom_addr_q;
    frame_d = frame_q + BLINK_W'(frame_tick);
    out_valid_d = sb_valid;
    out_px_d = sb_valid ? mode_px : out_px_q;
    err_d = (sb_valid && is_err) || (err_q && !err_clr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q  <= '0;
      frame_q     <= '0;
      out_valid_q <= 1'b0;
      out_px_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      rom_addr_q  <= rom_addr_d;
      frame_q     <= frame_d;
      out_valid_q <= out_valid_d;
      out_px_q    <= out_px_d;
      err_q       <= err_d;
    end
  end
  assign rom_addr   = rom_addr_q;
  assign out_valid  = out_valid_q;
  assign out_px     = out_px_q;
  assign err_sticky = err_q;
endmodule

// File: tb/tb_tile_px_fetch.sv
// tb_tile_px_fetch: scoreboard bench driving ROM_LAT=1 and ROM_LAT=3 instances in lockstep
module tb_tile_px_fetch;
  localparam int NT = 12;
  localparam int PW = 24;
  typedef struct {
    logic [23:0] px;
    int          cyc;
    logic        err;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [3:0] in_code = '0;
  logic [5:0] in_x = '0;
  logic [5:0] in_y = '0;
  logic [1:0] in_mode = '0;
  logic frame_tick = 1'b0;
  logic err_clr = 1'b0;
  logic [11:0] addr1, addr3;
  logic [NT*PW-1:0] rd1, rd3;
  logic ov1, ov3, es1, es3;
  logic [23:0] px1, px3;
  logic [11:0] p1;
  logic [11:0] p3 [3];
  exp_t q1[$];
  exp_t q3[$];
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int frame_m = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  tile_px_fetch #(.ROM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .in_x(in_x), .in_y(in_y),
    .in_mode(in_mode), .frame_tick(frame_tick), .err_clr(err_clr), .rom_addr(addr1),
    .rom_data(rd1), .out_valid(ov1), .out_px(px1), .err_sticky(es1)
  );
  tile_px_fetch #(.ROM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .in_x(in_x), .in_y(in_y),
    .in_mode(in_mode), .frame_tick(frame_tick), .err_clr(err_clr), .rom_addr(addr3),
    .rom_data(rd3), .out_valid(ov3), .out_px(px3), .err_sticky(es3)
  );
  function automatic logic [23:0] rom_word(input int k, input logic [11:0] a);
    return {4'(k), a, 8'(a * 3 + k * 17)};
  endfunction
  function automatic logic [23:0] exp_px(input logic [3:0] code, input logic [11:0] a,
                                         input logic [1:0] mode, input logic phase);
    logic [23:0] b;
    if (code > 4'd12) return 24'hFF00FF;
    b = code == 4'd0 ? 24'hCDC1B4 : rom_word(int'(code) - 1, a);
    case (mode)
      2'b01:   return {1'b0, b[23:17], 1'b0, b[15:9], 1'b0, b[7:1]};
      2'b10:   return phase ? 24'hCDC1B4 : b;
      2'b11:   return ~b;
      default: return b;
    endcase
  endfunction
  // ROM bank models: word appears ROM_LAT edges after the registered address
  always @(posedge clk) begin
    p1 <= addr1;
    p3[0] <= addr3;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  always_comb begin
    rd1 = '0;
    rd3 = '0;
    for (int k = 0; k < NT; k++) begin
      rd1[k*PW +: PW] = rom_word(k, p1);
      rd3[k*PW +: PW] = rom_word(k, p3[2]);
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (ov1 === 1'b1) begin
      chk("dut1_valid_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("dut1_px", 32'(px1), 32'(e.px));
        chk("dut1_latency", 32'(cyc), 32'(e.cyc));
        if (e.err) chk("dut1_err_same_edge", 32'(es1), 32'd1);
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (ov3 === 1'b1) begin
      chk("dut3_valid_expected", 32'(q3.size() != 0), 32'd1);
      if (q3.size() != 0) begin
        e = q3.pop_front();
        chk("dut3_px", 32'(px3), 32'(e.px));
        chk("dut3_latency", 32'(cyc), 32'(e.cyc));
        if (e.err) chk("dut3_err_same_edge", 32'(es3), 32'd1);
      end
    end
  end
  task automatic req(input logic [3:0] code, input logic [5:0] x, input logic [5:0] y,
                     input logic [1:0] mode, input logic tick = 1'b0, input logic clr = 1'b0);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_code = code;
    in_x = x;
    in_y = y;
    in_mode = mode;
    frame_tick = tick;
    err_clr = clr;
    e.px = exp_px(code, {y, x}, mode, frame_m[4]);
    e.err = code > 4'd12;
    e.cyc = cyc + 3;
    q1.push_back(e);
    e.cyc = cyc + 5;
    q3.push_back(e);
    if (tick) frame_m = (frame_m + 1) % 32;
  endtask
  task automatic idle(input int n, input logic tick = 1'b0, input logic clr = 1'b0);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      frame_tick = tick;
      err_clr = clr;
      if (tick) frame_m = (frame_m + 1) % 32;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    frame_tick = 1'b0;
    err_clr = 1'b0;
    @(posedge clk);
    q1.delete();
    q3.delete();
    frame_m = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic check_rst(input string tag);
    chk({tag, "_ov1"}, 32'(ov1), 32'd0);
    chk({tag, "_px1"}, 32'(px1), 32'd0);
    chk({tag, "_addr1"}, 32'(addr1), 32'd0);
    chk({tag, "_err1"}, 32'(es1), 32'd0);
    chk({tag, "_ov3"}, 32'(ov3), 32'd0);
    chk({tag, "_px3"}, 32'(px3), 32'd0);
    chk({tag, "_addr3"}, 32'(addr3), 32'd0);
    chk({tag, "_err3"}, 32'(es3), 32'd0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_rst("reset");
    req(4'd3, 6'd5, 6'd2, 2'b00);
    idle(1);
    chk("rom_addr1_085", 32'(addr1), 32'h085);
    chk("rom_addr3_085", 32'(addr3), 32'h085);
    idle(4);
    for (int k = 1; k <= 12; k++) req(4'(k), 6'(k * 5), 6'(k * 3), 2'b00);
    idle(6);
    req(4'd0, 6'd1, 6'd1, 2'b00);
    req(4'd0, 6'd1, 6'd1, 2'b01);
    req(4'd0, 6'd1, 6'd1, 2'b11);
    req(4'd9, 6'd33, 6'd17, 2'b01);
    req(4'd11, 6'd2, 6'd40, 2'b11);
    idle(6);
    chk("err_clear_before", 32'(es1), 32'd0);
    req(4'd13, 6'd0, 6'd0, 2'b11);
    idle(6);
    chk("err1_set", 32'(es1), 32'd1);
    chk("err3_set", 32'(es3), 32'd1);
    req(4'd15, 6'd3, 6'd3, 2'b00);
    idle(1);
    idle(1, 1'b0, 1'b1);
    idle(1);
    chk("err1_set_wins_over_clr", 32'(es1), 32'd1);
    idle(4);
    chk("err1_still_set", 32'(es1), 32'd1);
    chk("err3_still_set", 32'(es3), 32'd1);
    idle(1, 1'b0, 1'b1);
    idle(1);
    chk("err1_cleared", 32'(es1), 32'd0);
    chk("err3_cleared", 32'(es3), 32'd0);
    req(4'd4, 6'd7, 6'd9, 2'b10);
    idle(15, 1'b1);
    req(4'd4, 6'd7, 6'd9, 2'b10, 1'b1);
    req(4'd4, 6'd7, 6'd9, 2'b10);
    req(4'd0, 6'd7, 6'd9, 2'b10);
    idle(6);
    req(4'd5, 6'd1, 6'd2, 2'b00);
    req(4'd6, 6'd3, 6'd4, 2'b01);
    req(4'd7, 6'd5, 6'd6, 2'b11);
    do_reset();
    idle(8);
    check_rst("post_rst");
    req(4'd4, 6'd1, 6'd1, 2'b10);
    idle(10);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/tile_px_fetch.md
Name: tile_px_fetch

Overview:
- Parametrised, pipelined pixel fetch stage for the 2048 board renderer.
- Takes a per-pixel request (tile code, in-tile x/y, render mode) and issues one shared address to an external bank of NUM_TILES tile ROMs.
- Selects the correct ROM word, delayed to match ROM latency, and applies blank/error/dim/blink/invert processing.
- Sits between the VGA/board scan logic and the colour output register. The ROM bank is instantiated outside this block and presented as one flattened data bus.

Parameters:
- NUM_TILES, 12, number of tile ROMs; tile code k in 1..NUM_TILES selects ROM k-1.
- CODE_W, 4, tile code width; requires 2^CODE_W > NUM_TILES.
- COORD_W, 6, in-tile x and y width; tile is 2^COORD_W square.
- ADDR_W, 12, ROM address width; must equal 2*COORD_W.
- PX_W, 24, pixel width; must be a multiple of 3 (R,G,B channels, MSB = R).
- ROM_LAT, 1, ROM read latency in cycles; legal range 1..4.
- BG_COLOR, 24'hCDC1B4, colour for empty tiles and blink-off.
- ERR_COLOR, 24'hFF00FF, colour for out-of-range codes.
- BLINK_W, 5, frame counter width; blink phase is the counter MSB.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  pixel request strobe, one per cycle max
- in_code  in  CODE_W  tile code, 0 = empty
- in_x  in  COORD_W  column within tile
- in_y  in  COORD_W  row within tile
- in_mode  in  2  00 normal, 01 dim, 10 blink, 11 invert
- frame_tick  in  1  one-cycle pulse per frame
- err_clr  in  1  clears err_sticky
- rom_addr  out  ADDR_W  shared address to all tile ROMs
- rom_data  in  NUM_TILES*PX_W  flattened ROM outputs; slice k = ROM k
- out_valid  out  1  pixel result strobe
- out_px  out  PX_W  processed pixel
- err_sticky  out  1  set when any out-of-range code is accepted

Behaviour:
- Clock and reset: clk and rst. Reset is synchronous and active-high, sampled on the clk rising edge.
- Reset values: rom_addr=0, out_valid=0, out_px=0, err_sticky=0, frame counter=0, all pipeline valid bits=0.
- Reset mid-operation drops every in-flight request. No out_valid is produced for requests accepted before the reset.
- Stage A (cycle N, in_valid=1): rom_addr <= {in_y, in_x} is registered at edge N+1. Code, mode and the current blink phase are captured into the sideband pipe.
- The sideband pipe (valid, code, mode, phase) is ROM_LAT+1 deep, so the selected ROM word is aligned with its own request. The select is never taken from the live in_code.
- Stage B, at edge N+2+ROM_LAT:
  - out_valid=1 and out_px=f(word).
  - Total latency is ROM_LAT+2 cycles. Throughput is 1 pixel/cycle, with no backpressure.
- rom_addr holds its last value when in_valid=0.
- Base word:
  - code=0 -> BG_COLOR.
  - 1<=code<=NUM_TILES -> rom_data slice code-1.
  - code>NUM_TILES -> ERR_COLOR.
- Error codes bypass all mode processing.
- Modes are applied to the base word (including BG):
  - dim: each PX_W/3-bit channel is shifted right by 1.
  - blink: BG_COLOR when captured phase=1, else the base word.
  - invert: bitwise NOT.
- err_sticky is set at the same edge as the erroring pixel's out_valid. It stays set until err_clr or rst.
- If err_clr and a new error occur in the same cycle, set wins.
- Frame counter increments (wraps at 2^BLINK_W) on frame_tick.
- If frame_tick and in_valid occur in the same cycle, the request captures the pre-increment phase.
- out_valid is 0 on any cycle with no matured request. out_px holds its last value when out_valid=0.

Decomposition:
- Shared package tile_pkg holds:
  - mode encodings MODE_NORMAL/DIM/BLINK/INVERT;
  - CODE_EMPTY=0;
  - BG_COLOR and ERR_COLOR defaults;
  - the tile-code-to-value mapping (code k = 2^(k-1) for k>=2, index tile = 1), shared with board logic.
- One natural sub-module, px_sideband_pipe: a parametrised-depth shift register carrying {valid, code, mode, phase}, with synchronous clear. It is reused by the text overlay path.

Test Plan:
- Reset, then a single request code=3, x=5, y=2, ROM_LAT=1 -> rom_addr=12'h085 one cycle later. out_valid pulses exactly 3 cycles after in_valid, with out_px = ROM2 word at 0x085.
- Back-to-back requests with code=1,2,...,12 on consecutive cycles, each ROM returning a distinct word -> 12 consecutive out_valid cycles, each pixel from the matching ROM. This checks select/latency alignment.
- code=0 in normal, dim and invert modes -> CDC1B4, 66605A, 323E4B.
- code=13 -> out_px=FF00FF and err_sticky=1 at the same edge. err_clr together with another code=13 leaves err_sticky=1; err_clr alone clears it.
- Blink mode, code=4, with 16 frame_ticks applied -> pixels before show the ROM word, pixels after show BG. A frame_tick coincident with a request uses the old phase.
- Assert rst while 3 requests are in flight -> no out_valid afterwards, all outputs at reset values. Repeat with ROM_LAT=3 to check latency=5.
